// File: rtl/mem_responder.sv
// Word-addressed memory endpoint for a split valid/ready bus: one outstanding read
// with programmable latency, one-entry write address/data holding. Optional MEM_RESPONDER_STALL_EN.
module mem_responder #(
  parameter int bus_width    = 32,
  parameter int addr_width   = 10,
  parameter int read_latency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [bus_width-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [bus_width-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [bus_width-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [bus_width-1:0] wdata
);

  // state  | meaning
  // R_IDLE | accepting a read address
  // R_WAIT | latency countdown; data loads on the edge leaving with cnt == 0
  // R_RESP | rdata_valid held until the initiator accepts
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;

  localparam logic [3:0] LAT_M1 = 4'(read_latency - 1);

  rstate_t                 state, state_nxt;
  logic [3:0]              cnt;
  logic [addr_width-1:0]   rd_idx, wr_idx;
  logic [bus_width-1:0]    wr_data;
  logic                    addr_full, data_full, addr_full_nxt, data_full_nxt;
  logic                    raddr_hs, rdata_hs, waddr_hs, wdata_hs, commit;
  logic                    load_rdata, raddr_ready_nxt;
  logic                    stall_nxt;
  logic [bus_width-1:0]    mem [2**addr_width];
  logic                    unused_addr_bits;

  assign raddr_hs = raddr_valid && raddr_ready;
  assign rdata_hs = rdata_valid && rdata_ready;
  assign waddr_hs = waddr_valid && waddr_ready;
  assign wdata_hs = wdata_valid && wdata_ready;
  assign commit   = addr_full && data_full;

  assign unused_addr_bits = ^{raddr[1:0], raddr[bus_width-1:addr_width+2],
                              waddr[1:0], waddr[bus_width-1:addr_width+2]};

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr, lfsr_nxt;

  // x^8+x^6+x^5+x^4+1; readies are registered, so gate them with the upcoming bit
  assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall_nxt = lfsr_nxt[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= lfsr_nxt;
  end
`else
  assign stall_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= R_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (raddr_hs) state_nxt = R_WAIT;
      R_WAIT:  if (cnt == 4'd0) state_nxt = R_RESP;
      R_RESP:  if (rdata_hs) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    load_rdata      = (state == R_WAIT) && (cnt == 4'd0);
    raddr_ready_nxt = (state_nxt == R_IDLE) && !stall_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 4'd0;
      rd_idx      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      raddr_ready <= 1'b0;
    end else begin
      raddr_ready <= raddr_ready_nxt;
      if (raddr_hs) begin
        rd_idx <= raddr[addr_width+1:2];
        cnt    <= LAT_M1;
      end else if (state == R_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Array read is sampled before any same-edge commit lands: read-before-write
      if (load_rdata) begin
        rdata       <= mem[rd_idx];
        rdata_valid <= 1'b1;
      end else if (rdata_hs) begin
        rdata_valid <= 1'b0;
      end
    end
  end

  assign addr_full_nxt = commit ? 1'b0 : (addr_full | waddr_hs);
  assign data_full_nxt = commit ? 1'b0 : (data_full | wdata_hs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_full   <= 1'b0;
      data_full   <= 1'b0;
      waddr_ready <= 1'b0;
      wdata_ready <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= '0;
    end else begin
      addr_full   <= addr_full_nxt;
      data_full   <= data_full_nxt;
      waddr_ready <= !addr_full_nxt && !stall_nxt;
      wdata_ready <= !data_full_nxt && !stall_nxt;
      if (waddr_hs) wr_idx  <= waddr[addr_width+1:2];
      if (wdata_hs) wr_data <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_idx] <= wr_data;
  end

endmodule
